// File: rtl/aes_sbox_multicycle_if.sv
// Coprocessor handshake bundle for the multi-cycle AES byte-substitution unit.
interface aes_sbox_multicycle_if;
    logic        valid;
    logic        dec;
    logic [31:0] rs1;
    logic        ready;
    logic [31:0] rd;
    logic        busy;

    modport master (
        output valid, dec, rs1,
        input  ready, rd, busy
    );

    modport slave (
        input  valid, dec, rs1,
        output ready, rd, busy
    );
endinterface

// File: rtl/aes_sbox_multicycle.sv
// AES forward/inverse SBox applied to a 32-bit word, LANES bytes per cycle.

// Combinational AES SBox: forward (inv=0) or inverse (inv=1).
// Built from GF(2^8) inversion plus the affine map rather than a lookup table.
module aes_sbox (
    input  logic [7:0] in,
    input  logic       inv,
    output logic [7:0] out
);
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int unsigned i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
        end
        return p;
    endfunction

    // a^254 == a^-1 in GF(2^8); maps 0 to 0 as the SBox requires.
    function automatic logic [7:0] ginv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] s;
        r = 8'h01;
        s = a;
        for (int unsigned i = 1; i < 8; i++) begin
            s = gmul(s, s);
            r = gmul(r, s);
        end
        return r;
    endfunction

    function automatic logic [7:0] fwd_affine(input logic [7:0] b);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                 ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_affine(input logic [7:0] b);
        return {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
    endfunction

    assign out = inv ? ginv(inv_affine(in)) : fwd_affine(ginv(in));
endmodule

module aes_sbox_multicycle #(
    parameter int unsigned LANES = 4
) (
    input  logic                  g_clk,
    input  logic                  g_resetn,
    aes_sbox_multicycle_if.slave  bus
);
    if (!(LANES == 1 || LANES == 2 || LANES == 4)) begin : g_bad_lanes
        $error("aes_sbox_multicycle: LANES must be 1, 2 or 4");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0] STEP      = 2'(LANES);
    localparam logic [1:0] LAST_BASE = 2'(4 - LANES);

    state_t      state_q, state_d;
    logic [1:0]  cnt_q;
    logic [31:0] word_q;
    logic        dec_q;
    logic [31:0] res_q;

    logic [1:0]  idx    [LANES];
    logic [7:0]  sb_in  [LANES];
    logic [7:0]  sb_out [LANES];

    // Byte positions handled this cycle and the latched bytes feeding the SBoxes.
    always_comb begin
        idx   = '{default: '0};
        sb_in = '{default: '0};
        for (int unsigned l = 0; l < LANES; l++) begin
            idx[l]   = cnt_q + 2'(l);
            sb_in[l] = word_q[{idx[l], 3'b000} +: 8];
        end
    end

    for (genvar g = 0; g < int'(LANES); g++) begin : g_lane
        aes_sbox u_sbox (
            .in  (sb_in[g]),
            .inv (dec_q),
            .out (sb_out[g])
        );
    end

    // FSM state register.
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) state_q <= IDLE;
        else           state_q <= state_d;
    end

    // Next state: abort on dropped valid takes priority over completing the last group.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (bus.valid) state_d = BUSY;
            BUSY: begin
                if (!bus.valid)              state_d = IDLE;
                else if (cnt_q == LAST_BASE) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Request latch, byte counter and result register.
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            word_q <= '0;
            dec_q  <= 1'b0;
            res_q  <= '0;
            cnt_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.valid) begin
                        word_q <= bus.rs1;
                        dec_q  <= bus.dec;
                        res_q  <= '0;
                        cnt_q  <= '0;
                    end
                end
                BUSY: begin
                    // The write happens even in an aborting cycle.
                    for (int unsigned l = 0; l < LANES; l++) begin
                        res_q[{idx[l], 3'b000} +: 8] <= sb_out[l];
                    end
                    cnt_q <= cnt_q + STEP;
                end
                default: ;
            endcase
        end
    end

    assign bus.ready = (state_q == DONE);
    assign bus.busy  = (state_q != IDLE);
    assign bus.rd    = res_q;
endmodule

// File: tb/tb_aes_sbox_multicycle.sv
// Directed and randomised checks of aes_sbox_multicycle for LANES = 4, 2, 1.
module tb_aes_sbox_multicycle;
    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Index 0: LANES=4, 1: LANES=2, 2: LANES=1
    logic        valid_s [3];
    logic        dec_s   [3];
    logic [31:0] rs1_s   [3];
    logic        ready_s [3];
    logic        busy_s  [3];
    logic [31:0] rd_s    [3];

    aes_sbox_multicycle_if bus4 ();
    aes_sbox_multicycle_if bus2 ();
    aes_sbox_multicycle_if bus1 ();

    assign bus4.valid = valid_s[0];
    assign bus4.dec   = dec_s[0];
    assign bus4.rs1   = rs1_s[0];
    assign ready_s[0] = bus4.ready;
    assign busy_s[0]  = bus4.busy;
    assign rd_s[0]    = bus4.rd;

    assign bus2.valid = valid_s[1];
    assign bus2.dec   = dec_s[1];
    assign bus2.rs1   = rs1_s[1];
    assign ready_s[1] = bus2.ready;
    assign busy_s[1]  = bus2.busy;
    assign rd_s[1]    = bus2.rd;

    assign bus1.valid = valid_s[2];
    assign bus1.dec   = dec_s[2];
    assign bus1.rs1   = rs1_s[2];
    assign ready_s[2] = bus1.ready;
    assign busy_s[2]  = bus1.busy;
    assign rd_s[2]    = bus1.rd;

    aes_sbox_multicycle #(.LANES(4)) dut4 (.g_clk(clk), .g_resetn(resetn), .bus(bus4));
    aes_sbox_multicycle #(.LANES(2)) dut2 (.g_clk(clk), .g_resetn(resetn), .bus(bus2));
    aes_sbox_multicycle #(.LANES(1)) dut1 (.g_clk(clk), .g_resetn(resetn), .bus(bus1));

    // Standard AES forward SBox table.
    byte unsigned sbox_tab [256] = '{
        8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
        8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
        8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
        8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
        8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
        8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
        8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
        8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
        8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
        8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
        8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
        8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
        8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
        8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
        8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
        8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
    };
    byte unsigned inv_tab [256];

    function automatic int lat_of(input int s);
        return (s == 0) ? 2 : (s == 1) ? 3 : 5;
    endfunction

    function automatic logic [31:0] model(input logic [31:0] w, input logic d);
        logic [31:0] r;
        logic [7:0]  b;
        r = '0;
        for (int k = 0; k < 4; k++) begin
            b = w[8*k +: 8];
            r[8*k +: 8] = d ? inv_tab[b] : sbox_tab[b];
        end
        return r;
    endfunction

    // Issue one request at the current negedge (DUT idle), hold valid until ready.
    task automatic run_req(input int s, input logic d, input logic [31:0] w,
                           output logic [31:0] res, output int lat);
        valid_s[s] = 1'b1;
        dec_s[s]   = d;
        rs1_s[s]   = w;
        lat = 0;
        res = '0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (ready_s[s] === 1'b1) begin
                lat = c;
                res = rd_s[s];
                break;
            end
        end
        valid_s[s] = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        for (int s = 0; s < 3; s++) begin
            checks++;
            if (ready_s[s] !== 1'b0) begin
                errors++; $display("FAIL reset_ready[%0d]: got %b expected 0", s, ready_s[s]);
            end
            checks++;
            if (busy_s[s] !== 1'b0) begin
                errors++; $display("FAIL reset_busy[%0d]: got %b expected 0", s, busy_s[s]);
            end
            checks++;
            if (rd_s[s] !== 32'h0) begin
                errors++; $display("FAIL reset_rd[%0d]: got %h expected 00000000", s, rd_s[s]);
            end
        end
    endtask

    task automatic test_forward_lanes4();
        valid_s[0] = 1'b1; dec_s[0] = 1'b0; rs1_s[0] = 32'hFF530100;
        checks++;
        if (busy_s[0] !== 1'b0) begin
            errors++; $display("FAIL fwd4_busy_c0: got %b expected 0", busy_s[0]);
        end
        for (int cyc = 1; cyc <= 3; cyc++) begin
            @(negedge clk);
            checks++;
            if (ready_s[0] !== (cyc == 2)) begin
                errors++; $display("FAIL fwd4_ready_c%0d: got %b expected %b", cyc, ready_s[0], cyc == 2);
            end
            checks++;
            if (busy_s[0] !== (cyc <= 2)) begin
                errors++; $display("FAIL fwd4_busy_c%0d: got %b expected %b", cyc, busy_s[0], cyc <= 2);
            end
            if (cyc >= 2) begin
                checks++;
                if (rd_s[0] !== 32'h16ED7C63) begin
                    errors++; $display("FAIL fwd4_rd_c%0d: got %h expected 16ed7c63", cyc, rd_s[0]);
                end
            end
            if (cyc == 2) valid_s[0] = 1'b0;
        end
    endtask

    task automatic test_input_stability();
        valid_s[2] = 1'b1; dec_s[2] = 1'b1; rs1_s[2] = 32'h16ED7C63;
        for (int cyc = 1; cyc <= 6; cyc++) begin
            @(negedge clk);
            if (cyc == 2) begin
                rs1_s[2] = 32'h0;
                dec_s[2] = 1'b0;
            end
            checks++;
            if (ready_s[2] !== (cyc == 5)) begin
                errors++; $display("FAIL stab_ready_c%0d: got %b expected %b", cyc, ready_s[2], cyc == 5);
            end
            checks++;
            if (busy_s[2] !== (cyc <= 5)) begin
                errors++; $display("FAIL stab_busy_c%0d: got %b expected %b", cyc, busy_s[2], cyc <= 5);
            end
            if (cyc == 5) begin
                checks++;
                if (rd_s[2] !== 32'hFF530100) begin
                    errors++; $display("FAIL stab_rd: got %h expected ff530100", rd_s[2]);
                end
                valid_s[2] = 1'b0;
            end
        end
    endtask

    task automatic test_back_to_back();
        logic exp_busy;
        valid_s[1] = 1'b1; dec_s[1] = 1'b0; rs1_s[1] = 32'h00000000;
        for (int cyc = 1; cyc <= 8; cyc++) begin
            @(negedge clk);
            exp_busy = (cyc != 4) && (cyc != 8);
            checks++;
            if (ready_s[1] !== (cyc == 3 || cyc == 7)) begin
                errors++; $display("FAIL b2b_ready_c%0d: got %b expected %b", cyc, ready_s[1], cyc == 3 || cyc == 7);
            end
            checks++;
            if (busy_s[1] !== exp_busy) begin
                errors++; $display("FAIL b2b_busy_c%0d: got %b expected %b", cyc, busy_s[1], exp_busy);
            end
            if (cyc == 3) begin
                checks++;
                if (rd_s[1] !== 32'h63636363) begin
                    errors++; $display("FAIL b2b_rd_first: got %h expected 63636363", rd_s[1]);
                end
                rs1_s[1] = 32'h01010101;
            end
            if (cyc == 7) begin
                checks++;
                if (rd_s[1] !== 32'h7C7C7C7C) begin
                    errors++; $display("FAIL b2b_rd_second: got %h expected 7c7c7c7c", rd_s[1]);
                end
                valid_s[1] = 1'b0;
            end
        end
    endtask

    task automatic test_abort();
        logic [31:0] res;
        int          lat;
        logic        saw_ready;
        valid_s[2] = 1'b1; dec_s[2] = 1'b0; rs1_s[2] = 32'hFF530100;
        @(negedge clk);
        checks++;
        if (busy_s[2] !== 1'b1) begin
            errors++; $display("FAIL abort_busy_c1: got %b expected 1", busy_s[2]);
        end
        @(negedge clk);
        valid_s[2] = 1'b0;
        @(negedge clk);
        checks++;
        if (busy_s[2] !== 1'b0) begin
            errors++; $display("FAIL abort_busy_c3: got %b expected 0", busy_s[2]);
        end
        checks++;
        if (rd_s[2] !== 32'h00007C63) begin
            errors++; $display("FAIL abort_partial_rd: got %h expected 00007c63", rd_s[2]);
        end
        saw_ready = ready_s[2];
        for (int cyc = 4; cyc <= 8; cyc++) begin
            @(negedge clk);
            saw_ready = saw_ready | ready_s[2];
        end
        checks++;
        if (saw_ready !== 1'b0) begin
            errors++; $display("FAIL abort_no_ready: got %b expected 0", saw_ready);
        end
        run_req(2, 1'b0, 32'hFF530100, res, lat);
        checks++;
        if (res !== 32'h16ED7C63) begin
            errors++; $display("FAIL abort_retry_rd: got %h expected 16ed7c63", res);
        end
        checks++;
        if (lat != 5) begin
            errors++; $display("FAIL abort_retry_lat: got %0d expected 5", lat);
        end
    endtask

    task automatic test_reset_mid_op();
        logic [31:0] res;
        int          lat;
        valid_s[1] = 1'b1; dec_s[1] = 1'b0; rs1_s[1] = 32'hFF530100;
        @(negedge clk);
        checks++;
        if (busy_s[1] !== 1'b1) begin
            errors++; $display("FAIL rstmid_busy_before: got %b expected 1", busy_s[1]);
        end
        #1 resetn = 1'b0;
        #1;
        test_reset();
        @(negedge clk);
        valid_s[1] = 1'b0;
        resetn = 1'b1;
        @(negedge clk);
        checks++;
        if (busy_s[1] !== 1'b0) begin
            errors++; $display("FAIL rstmid_busy_after: got %b expected 0", busy_s[1]);
        end
        run_req(1, 1'b0, 32'h53535353, res, lat);
        checks++;
        if (res !== 32'hEDEDEDED) begin
            errors++; $display("FAIL rstmid_retry_rd: got %h expected edededed", res);
        end
        checks++;
        if (lat != 3) begin
            errors++; $display("FAIL rstmid_retry_lat: got %0d expected 3", lat);
        end
    endtask

    task automatic test_random_sweep();
        logic [31:0] w, fwd, back;
        int          lat;
        for (int s = 0; s < 3; s++) begin
            for (int n = 0; n < 1000; n++) begin
                w = $urandom;
                repeat ($urandom_range(0, 2)) @(negedge clk);
                run_req(s, 1'b0, w, fwd, lat);
                checks++;
                if (fwd !== model(w, 1'b0) || lat != lat_of(s)) begin
                    errors++;
                    $display("FAIL rand_fwd[%0d]: in %h got %h lat %0d expected %h lat %0d",
                             s, w, fwd, lat, model(w, 1'b0), lat_of(s));
                end
                repeat ($urandom_range(0, 2)) @(negedge clk);
                run_req(s, 1'b1, fwd, back, lat);
                checks++;
                if (back !== w || lat != lat_of(s)) begin
                    errors++;
                    $display("FAIL rand_inv[%0d]: in %h got %h lat %0d expected %h lat %0d",
                             s, fwd, back, lat, w, lat_of(s));
                end
            end
        end
    endtask

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 256; i++) inv_tab[sbox_tab[i]] = 8'(i);
        resetn = 1'b0;
        for (int s = 0; s < 3; s++) begin
            valid_s[s] = 1'b0;
            dec_s[s]   = 1'b0;
            rs1_s[s]   = '0;
        end
        repeat (2) @(negedge clk);
        test_reset();
        resetn = 1'b1;
        @(negedge clk);
        test_forward_lanes4();
        test_input_stability();
        test_back_to_back();
        test_abort();
        test_reset_mid_op();
        test_random_sweep();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
